// File: rtl/tage_tables_if.sv
// Purpose: lookup/update bus between the TAGE predictor top and its component tables.
// Latency: none; plain wires grouping the request and response fields.
// Backpressure: none; the tables sample the request on every rising clock edge.
//
// Ports (master = predictor top, slave = tables):
//   br_result_i, idx_i, hash_idx_i, hash_tag_i, provider_i, update_u_i : request
//   base_prediction_o, prediction_o, tag_hit_o                          : response
interface tage_tables_if #(
  parameter int NUM_TAGGED     = 4,
  parameter int TAGE_IDX_WIDTH = 9,
  parameter int TAG_WIDTH      = 10
);
  logic                                 br_result_i;
  logic [31:0]                          idx_i;
  logic [NUM_TAGGED*TAGE_IDX_WIDTH-1:0] hash_idx_i;
  logic [NUM_TAGGED*TAG_WIDTH-1:0]      hash_tag_i;
  logic [NUM_TAGGED-1:0]                provider_i;
  logic [NUM_TAGGED-1:0]                update_u_i;
  logic                                 base_prediction_o;
  logic [NUM_TAGGED-1:0]                prediction_o;
  logic [NUM_TAGGED-1:0]                tag_hit_o;

  modport master (
    output br_result_i, idx_i, hash_idx_i, hash_tag_i, provider_i, update_u_i,
    input  base_prediction_o, prediction_o, tag_hit_o
  );

  modport slave (
    input  br_result_i, idx_i, hash_idx_i, hash_tag_i, provider_i, update_u_i,
    output base_prediction_o, prediction_o, tag_hit_o
  );
endinterface

// File: rtl/tage_tables.sv
// Purpose: TAGE component storage - bimodal base table T0 plus NUM_TAGGED tagged tables.
// Latency: lookups are combinational (zero cycles); updates land on the rising edge.
// Backpressure: none; every edge applies the update selected by provider_i/update_u_i.
//
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : asynchronous active-high reset
//   tbl_if : slave side of tage_tables_if (hashed request in, predictions/tag hits out)
module tage_tables #(
  parameter int NUM_TAGGED     = 4,
  parameter int BHT_IDX_WIDTH  = 10,
  parameter int TAGE_IDX_WIDTH = 9,
  parameter int TAG_WIDTH      = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  tage_tables_if.slave  tbl_if
);

  localparam int BHT_DEPTH  = 1 << BHT_IDX_WIDTH;
  localparam int TAGE_DEPTH = 1 << TAGE_IDX_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic [2:0]           ctr;
    logic [1:0]           u;
  } tage_entry_t;

  // ctr=3 is weak not-taken, so a cleared table predicts not-taken.
  localparam tage_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, ctr: 3'd3, u: 2'd0};

  logic [1:0]  bht_q  [BHT_DEPTH];
  tage_entry_t tage_q [NUM_TAGGED][TAGE_DEPTH];

  // Only the low PC bits index the base table.
  logic                     unused_idx_bits;
  logic [BHT_IDX_WIDTH-1:0] bht_idx;
  logic [1:0]               bht_cur;
  logic [1:0]               bht_nxt;

  assign unused_idx_bits = ^tbl_if.idx_i[31:BHT_IDX_WIDTH];
  assign bht_idx         = tbl_if.idx_i[BHT_IDX_WIDTH-1:0];
  assign bht_cur         = bht_q[bht_idx];

  always_comb begin
    bht_nxt = bht_cur;
    if (tbl_if.br_result_i && bht_cur != 2'd3) begin
      bht_nxt = bht_cur + 2'd1;
    end else if (!tbl_if.br_result_i && bht_cur != 2'd0) begin
      bht_nxt = bht_cur - 2'd1;
    end
  end

  logic [TAGE_IDX_WIDTH-1:0] rd_idx [NUM_TAGGED];
  logic [TAG_WIDTH-1:0]      rd_tag [NUM_TAGGED];
  tage_entry_t               rd_ent [NUM_TAGGED];
  tage_entry_t               wr_ent [NUM_TAGGED];
  logic [NUM_TAGGED-1:0]     hit;
  logic [NUM_TAGGED-1:0]     pred;

  always_comb begin
    hit  = '0;
    pred = '0;
    for (int k = 0; k < NUM_TAGGED; k++) begin
      rd_idx[k] = tbl_if.hash_idx_i[k*TAGE_IDX_WIDTH +: TAGE_IDX_WIDTH];
      rd_tag[k] = tbl_if.hash_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
      rd_ent[k] = tage_q[k][rd_idx[k]];
      hit[k]    = rd_ent[k].valid && (rd_ent[k].tag == rd_tag[k]);
      pred[k]   = rd_ent[k].ctr[2];
      wr_ent[k] = rd_ent[k];

      if (hit[k]) begin
        // Provider hit: train the counter; usefulness tracks whether the
        // pre-update prediction was right.
        if (tbl_if.br_result_i && rd_ent[k].ctr != 3'd7) begin
          wr_ent[k].ctr = rd_ent[k].ctr + 3'd1;
        end else if (!tbl_if.br_result_i && rd_ent[k].ctr != 3'd0) begin
          wr_ent[k].ctr = rd_ent[k].ctr - 3'd1;
        end
        if (tbl_if.update_u_i[k]) begin
          if (pred[k] == tbl_if.br_result_i) begin
            if (rd_ent[k].u != 2'd3) wr_ent[k].u = rd_ent[k].u + 2'd1;
          end else if (rd_ent[k].u != 2'd0) begin
            wr_ent[k].u = rd_ent[k].u - 2'd1;
          end
        end
      end else if (rd_ent[k].u == 2'd0) begin
        // Miss on a non-useful entry: replace it with a weak counter.
        wr_ent[k].valid = 1'b1;
        wr_ent[k].tag   = rd_tag[k];
        wr_ent[k].ctr   = tbl_if.br_result_i ? 3'd4 : 3'd3;
        wr_ent[k].u     = 2'd0;
      end else begin
        // Miss on a useful entry: age it so a later miss can replace it.
        wr_ent[k].u = rd_ent[k].u - 2'd1;
      end
    end
  end

  assign tbl_if.base_prediction_o = bht_cur[1];
  assign tbl_if.prediction_o      = pred;
  assign tbl_if.tag_hit_o         = hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'd1;
      end
      for (int k = 0; k < NUM_TAGGED; k++) begin
        for (int i = 0; i < TAGE_DEPTH; i++) begin
          tage_q[k][i] <= ENTRY_RST;
        end
      end
    end else begin
      bht_q[bht_idx] <= bht_nxt;
      for (int k = 0; k < NUM_TAGGED; k++) begin
        if (tbl_if.provider_i[k]) begin
          tage_q[k][rd_idx[k]] <= wr_ent[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_tage_tables.sv
// Purpose: self-checking bench for tage_tables (reference model scoreboard + directed checks).
// Latency: outputs sampled mid-cycle, away from the rising edge.
// Backpressure: none; one request is applied per clock.
module tb_tage_tables;
  localparam int NT = 4;
  localparam int BW = 10;
  localparam int TW = 9;
  localparam int GW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tage_tables_if #(.NUM_TAGGED(NT), .TAGE_IDX_WIDTH(TW), .TAG_WIDTH(GW)) bus ();

  tage_tables #(
    .NUM_TAGGED(NT), .BHT_IDX_WIDTH(BW), .TAGE_IDX_WIDTH(TW), .TAG_WIDTH(GW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .tbl_if(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model of the table contents.
  int bht_m [1 << BW];
  int vld_m [NT][1 << TW];
  int tag_m [NT][1 << TW];
  int ctr_m [NT][1 << TW];
  int u_m   [NT][1 << TW];

  task automatic model_reset();
    for (int i = 0; i < (1 << BW); i++) bht_m[i] = 1;
    for (int k = 0; k < NT; k++) begin
      for (int i = 0; i < (1 << TW); i++) begin
        vld_m[k][i] = 0; tag_m[k][i] = 0; ctr_m[k][i] = 3; u_m[k][i] = 0;
      end
    end
  endtask

  function automatic int ix_of(int k);
    logic [TW-1:0] v;
    v = bus.hash_idx_i[k*TW +: TW];
    return int'(v);
  endfunction

  function automatic int tg_of(int k);
    logic [GW-1:0] v;
    v = bus.hash_tag_i[k*GW +: GW];
    return int'(v);
  endfunction

  // {base_prediction, prediction[3:0], tag_hit[3:0]}
  function automatic logic [8:0] model_out();
    logic [8:0] r;
    r = '0;
    r[8] = (bht_m[int'(bus.idx_i[BW-1:0])] >= 2);
    for (int k = 0; k < NT; k++) begin
      r[4+k] = (ctr_m[k][ix_of(k)] >= 4);
      r[k]   = (vld_m[k][ix_of(k)] == 1) && (tag_m[k][ix_of(k)] == tg_of(k));
    end
    return r;
  endfunction

  task automatic model_update();
    int b, i, t, c, was_right;
    b = bus.br_result_i ? 1 : 0;
    i = int'(bus.idx_i[BW-1:0]);
    bht_m[i] = b ? ((bht_m[i] == 3) ? 3 : bht_m[i] + 1) : ((bht_m[i] == 0) ? 0 : bht_m[i] - 1);
    for (int k = 0; k < NT; k++) begin
      if (bus.provider_i[k]) begin
        i = ix_of(k);
        t = tg_of(k);
        c = ctr_m[k][i];
        if (vld_m[k][i] == 1 && tag_m[k][i] == t) begin
          ctr_m[k][i] = b ? ((c == 7) ? 7 : c + 1) : ((c == 0) ? 0 : c - 1);
          if (bus.update_u_i[k]) begin
            was_right = ((c >= 4) == (b == 1)) ? 1 : 0;
            if (was_right == 1) u_m[k][i] = (u_m[k][i] == 3) ? 3 : u_m[k][i] + 1;
            else                u_m[k][i] = (u_m[k][i] == 0) ? 0 : u_m[k][i] - 1;
          end
        end else if (u_m[k][i] == 0) begin
          vld_m[k][i] = 1; tag_m[k][i] = t; ctr_m[k][i] = b ? 4 : 3; u_m[k][i] = 0;
        end else begin
          u_m[k][i] = u_m[k][i] - 1;
        end
      end
    end
  endtask

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;
  sb_t sb_q[$];

  function automatic logic [8:0] dut_out();
    return {bus.base_prediction_o, bus.prediction_o, bus.tag_hit_o};
  endfunction

  logic [TW-1:0] hidx [NT];
  logic [GW-1:0] htag [NT];

  task automatic drive_hash();
    for (int k = 0; k < NT; k++) begin
      bus.hash_idx_i[k*TW +: TW] = hidx[k];
      bus.hash_tag_i[k*GW +: GW] = htag[k];
    end
  endtask

  task automatic set_req(input logic br, input logic [31:0] pc,
                         input logic [NT-1:0] prov, input logic [NT-1:0] upd);
    bus.br_result_i = br;
    bus.idx_i       = pc;
    bus.provider_i  = prov;
    bus.update_u_i  = upd;
    drive_hash();
  endtask

  // Called just after a falling edge with the request already driven: push
  // the model's expectation, compare against the DUT, then advance one clock.
  task automatic cycle(input string name);
    sb_t s;
    sb_t got;
    #1;
    if (rst) model_reset();
    s.name = name;
    s.exp  = model_out();
    sb_q.push_back(s);
    #1;
    got = sb_q.pop_front();
    check(got.name, {23'd0, dut_out()}, {23'd0, got.exp});
    if (!rst) model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NT; k++) begin hidx[k] = '0; htag[k] = '0; end
    set_req(1'b0, 32'd0, '0, '0);
    model_reset();
    @(negedge clk);

    // Reset outputs with random request content
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < NT; k++) begin
        hidx[k] = TW'($urandom_range(0, (1 << TW) - 1));
        htag[k] = GW'($urandom_range(0, (1 << GW) - 1));
      end
      set_req(1'($urandom_range(0, 1)), $urandom, NT'($urandom_range(0, 15)), NT'($urandom_range(0, 15)));
      #1 check("rst_out", {23'd0, dut_out()}, 32'd0);
      cycle("rst_sb");
    end
    rst = 1'b0;

    // T0 training at PC 0x40
    set_req(1'b1, 32'h40, '0, '0);
    #1 check("t0_c1", {31'd0, bus.base_prediction_o}, 32'd0);
    cycle("t0_up1");
    #1 check("t0_c2", {31'd0, bus.base_prediction_o}, 32'd1);
    cycle("t0_up2");
    bus.br_result_i = 1'b0;
    #1 check("t0_c3", {31'd0, bus.base_prediction_o}, 32'd1);
    cycle("t0_dn1");
    #1 check("t0_c2b", {31'd0, bus.base_prediction_o}, 32'd1);
    cycle("t0_dn2");
    #1 check("t0_c1b", {31'd0, bus.base_prediction_o}, 32'd0);
    cycle("t0_dn3");
    #1 check("t0_c0", {31'd0, bus.base_prediction_o}, 32'd0);
    cycle("t0_dn4");
    #1 check("t0_sat0", {31'd0, bus.base_prediction_o}, 32'd0);

    // Allocation in table 0
    hidx[0] = 9'd5; htag[0] = 10'h2A5;
    set_req(1'b1, 32'h100, 4'b0001, '0);
    #1 check("alloc_pre_hit", {31'd0, bus.tag_hit_o[0]}, 32'd0);
    cycle("alloc");
    set_req(1'b1, 32'h100, 4'b0000, '0);
    #1 check("alloc_hit", {31'd0, bus.tag_hit_o[0]}, 32'd1);
    check("alloc_pred", {31'd0, bus.prediction_o[0]}, 32'd1);
    cycle("alloc_read");
    htag[0] = 10'h155; drive_hash();
    #1 check("alloc_other_tag", {31'd0, bus.tag_hit_o[0]}, 32'd0);
    cycle("alloc_other");

    // Useful guard: two correct hits raise u to 2
    htag[0] = 10'h2A5;
    set_req(1'b1, 32'h104, 4'b0001, 4'b0001);
    cycle("u_inc1");
    cycle("u_inc2");
    htag[0] = 10'h111;
    set_req(1'b0, 32'h108, 4'b0001, 4'b0001);
    cycle("u_guard1");
    #1 check("u_guard1_kept", {31'd0, bus.tag_hit_o[0]}, 32'd0);
    cycle("u_guard2");
    #1 check("u_guard2_kept", {31'd0, bus.tag_hit_o[0]}, 32'd0);
    cycle("u_replace");
    set_req(1'b0, 32'h108, 4'b0000, '0);
    #1 check("u_replaced_hit", {31'd0, bus.tag_hit_o[0]}, 32'd1);
    check("u_replaced_pred", {31'd0, bus.prediction_o[0]}, 32'd0);
    cycle("u_replaced");

    // Counter saturation at index 9
    hidx[0] = 9'd9; htag[0] = 10'h0AA;
    set_req(1'b1, 32'h10C, 4'b0001, '0);
    cycle("sat_alloc");
    bus.br_result_i = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1 check("sat_dn_pred", {31'd0, bus.prediction_o[0]}, (n == 0) ? 32'd1 : 32'd0);
      cycle("sat_dn");
    end
    bus.br_result_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1 check("sat_up_pred", {31'd0, bus.prediction_o[0]}, 32'd0);
      cycle("sat_up");
    end
    #1 check("sat_up_flip", {31'd0, bus.prediction_o[0]}, 32'd1);

    // Independence: only tables 1 and 3 allocate
    for (int k = 0; k < NT; k++) begin
      hidx[k] = TW'(20 + k);
      htag[k] = GW'(10'h301 + k);
    end
    set_req(1'b1, 32'h200, 4'b1010, '0);
    #1 check("ind_pre", {28'd0, bus.tag_hit_o}, 32'd0);
    cycle("ind_alloc");
    set_req(1'b1, 32'h200, 4'b0000, '0);
    #1 check("ind_hit", {28'd0, bus.tag_hit_o}, 32'b1010);
    check("ind_pred", {28'd0, bus.prediction_o}, 32'b1010);
    cycle("ind_read");

    // Random mix on a small index/tag space so hits, misses and aging all occur
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < NT; k++) begin
        hidx[k] = TW'($urandom_range(0, 3));
        htag[k] = GW'($urandom_range(1, 3));
      end
      set_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)),
              NT'($urandom_range(0, 15)), NT'($urandom_range(0, 15)));
      cycle("rand");
    end

    // Mid-operation asynchronous reset
    for (int k = 0; k < NT; k++) begin
      hidx[k] = TW'(20 + k);
      htag[k] = GW'(10'h301 + k);
    end
    set_req(1'b1, 32'h200, 4'b1111, 4'b1111);
    #1 check("mid_pre_hit", {28'd0, bus.tag_hit_o}, 32'b1010);
    #1 rst = 1'b1;
    #1 check("mid_async_clr", {23'd0, dut_out()}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mid_no_update", {28'd0, bus.tag_hit_o}, 32'd0);
    set_req(1'b1, 32'h200, 4'b0000, '0);
    cycle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
